// File: rtl/video_pkg.sv
// Shared definitions for the video test-pattern generator.
// Holds the pattern-mode encoding, the colour-bar table and 640x480@60 defaults.
// No logic lives here; everything is constants, types and one lookup helper.
package video_pkg;

    // Pattern modes as presented on pattern_sel.
    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_SOLID   = 2'd3
    } pat_mode_t;

    // One 24-bit pixel, red in the most significant byte.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Default 640x480@60 raster timing.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CNT_W    = 12;

    // Colour bars, left to right. Entry 0 is the leftmost bar.
    localparam logic [7:0][23:0] BAR_TABLE = {
        24'h000000,   // 7 black
        24'h0000FF,   // 6 blue
        24'hFF0000,   // 5 red
        24'hFF00FF,   // 4 magenta
        24'h00FF00,   // 3 green
        24'h00FFFF,   // 2 cyan
        24'hFFFF00,   // 1 yellow
        24'hFFFFFF    // 0 white
    };

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        return rgb_t'(BAR_TABLE[idx]);
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster h/v counters with de/hsync/vsync/frame_start decode (unregistered decode).
// Latency: decode is combinational from the counter state; the caller registers it.
// No backpressure: free-running at one pixel per clock.
//
// Ports: clk_i/rst_n_i (sync active-low reset), h_o/v_o current counter state,
// de_o/hsync_o/vsync_o/frame_start_o decoded timing, line_end_o/frame_end_o
// flag the last pixel of a line / of a frame.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    output logic [CNT_W-1:0] h_o,
    output logic [CNT_W-1:0] v_o,
    output logic             de_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             frame_start_o,
    output logic             line_end_o,
    output logic             frame_end_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters must be able to hold TOTAL-1.
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
        $error("video_timing_gen: raster totals do not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             line_end;
    logic             frame_end;
    logic             hs_act;
    logic             vs_act;

    always_comb begin
        line_end  = (h_cnt_q == H_LAST);
        frame_end = line_end && (v_cnt_q == V_LAST);
        h_cnt_d   = line_end ? '0 : h_cnt_q + CNT_W'(1);
        v_cnt_d   = v_cnt_q;
        if (line_end) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        hs_act        = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vs_act        = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        h_o           = h_cnt_q;
        v_o           = v_cnt_q;
        de_o          = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        hsync_o       = hs_act ? HS_POL : !HS_POL;
        vsync_o       = vs_act ? VS_POL : !VS_POL;
        frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);
        line_end_o    = line_end;
        frame_end_o   = frame_end;
    end

endmodule

// File: rtl/video_test_pattern_gen.sv
// Raster timing plus 24-bit test-pattern pixels (bars, ramp, checkerboard, solid).
// Latency: one register; outputs at cycle n+1 describe counter state (h,v) at cycle n.
// No backpressure: one pixel per clock, always valid.
//
// Ports: clk, rst_n (sync active-low), pattern_sel/solid_rgb (sampled on the last
// pixel of each frame), red/green/blue/de/hsync/vsync/frame_start/h_pos/v_pos
// all registered and mutually aligned.
module video_test_pattern_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       pattern_sel,
    input  logic [23:0]      solid_rgb,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_start,
    output logic [CNT_W-1:0] h_pos,
    output logic [CNT_W-1:0] v_pos
);

    // Bars need an integral width; the ramp and checker index bits 7 and 5.
    if ((H_ACTIVE % 8) != 0 || H_ACTIVE < 8) begin : g_bad_active
        $error("video_test_pattern_gen: H_ACTIVE must be a non-zero multiple of 8");
    end
    if (CNT_W < 8) begin : g_bad_cnt_w
        $error("video_test_pattern_gen: CNT_W must be at least 8");
    end

    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);

    logic [CNT_W-1:0] t_h, t_v;
    logic             t_de, t_hs, t_vs, t_fs, t_line_end, t_frame_end;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL),
        .CNT_W    (CNT_W)
    ) u_timing (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .h_o           (t_h),
        .v_o           (t_v),
        .de_o          (t_de),
        .hsync_o       (t_hs),
        .vsync_o       (t_vs),
        .frame_start_o (t_fs),
        .line_end_o    (t_line_end),
        .frame_end_o   (t_frame_end)
    );

    // Bar sub-counter tracks the same h as the timing counter: both are zero
    // out of reset and both return to zero after the last pixel of a line.
    logic [CNT_W-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]       bar_idx_q, bar_idx_d;

    always_comb begin
        bar_cnt_d = bar_cnt_q + CNT_W'(1);
        bar_idx_d = bar_idx_q;
        if (t_line_end) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = '0;
            bar_idx_d = bar_idx_q + 3'd1;   // wraps during blanking, masked by de
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
        end else begin
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    // Pattern latch: loaded on the last pixel of the frame so the new mode
    // starts exactly at pixel (0,0) of the next frame.
    pat_mode_t mode_q, mode_d;
    rgb_t      solid_q, solid_d;

    always_comb begin
        mode_d  = mode_q;
        solid_d = solid_q;
        if (t_frame_end) begin
            mode_d  = pat_mode_t'(pattern_sel);
            solid_d = rgb_t'(solid_rgb);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= PAT_BARS;
            solid_q <= '0;
        end else begin
            mode_q  <= mode_d;
            solid_q <= solid_d;
        end
    end

    // Pixel mux on the current counter state; blanked outside active video.
    rgb_t pix_d;

    always_comb begin
        pix_d = '0;
        if (t_de) begin
            case (mode_q)
                PAT_BARS:    pix_d = bar_colour(bar_idx_q);
                PAT_RAMP:    pix_d = {3{t_h[7:0]}};
                PAT_CHECKER: pix_d = (t_h[5] == t_v[5]) ? 24'hFFFFFF : 24'h000000;
                PAT_SOLID:   pix_d = solid_q;
                default:     pix_d = '0;
            endcase
        end
    end

    // Single output register stage shared by every output field.
    rgb_t             pix_q;
    logic             de_q, hsync_q, vsync_q, fs_q;
    logic [CNT_W-1:0] h_pos_q, v_pos_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_q   <= '0;
            de_q    <= 1'b0;
            hsync_q <= !HS_POL;
            vsync_q <= !VS_POL;
            fs_q    <= 1'b0;
            h_pos_q <= '0;
            v_pos_q <= '0;
        end else begin
            pix_q   <= pix_d;
            de_q    <= t_de;
            hsync_q <= t_hs;
            vsync_q <= t_vs;
            fs_q    <= t_fs;
            h_pos_q <= t_h;
            v_pos_q <= t_v;
        end
    end

    assign red         = pix_q.r;
    assign green       = pix_q.g;
    assign blue        = pix_q.b;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;
    assign h_pos       = h_pos_q;
    assign v_pos       = v_pos_q;

endmodule
